// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game controller.
package genius_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADD,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        WAIT_ADD,
        ROUND_END,
        WIN,
        LOSE
    } state_t;

    // Wide enough for the largest supported palette (8 colours).
    localparam int COLOR_MAX_W = 3;
    typedef logic [COLOR_MAX_W-1:0] color_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 as a bit mask over the 16-bit register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned target_len(input logic [1:0] difficulty,
                                               input int unsigned addr_width);
        return (32'(difficulty) + 32'd1) * ((32'd1 << addr_width) >> 2);
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running Fibonacci LFSR; shifts left and feeds the tap parity into bit 0.
module genius_lfsr
    import genius_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS),
    parameter int               OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [OUT_W-1:0] rnd
);

    logic [WIDTH-1:0] q_reg, q_next;

    always_comb begin
        q_next = q_reg;
        if (en) begin
            q_next = {q_reg[WIDTH-2:0], ^(q_reg & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= SEED;
        end else begin
            q_reg <= q_next;
        end
    end

    assign rnd = q_reg[OUT_W-1:0];

endmodule

// File: rtl/genius_ctrl_n.sv
// Genius (Simon) game controller: sequence generation, LED playback,
// player entry checking and per-press timeout.
module genius_ctrl_n
    import genius_pkg::*;
#(
    parameter int NUM_COLORS     = 4,
    parameter int COLOR_CODEFY_W = 2,
    parameter int ADDR_WIDTH     = 5,
    parameter int LFSR_WIDTH     = 16,
    parameter int SHOW_CYC       = 50_000_000,
    parameter int TIMEOUT_CYC    = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode_button,
    input  logic [1:0]            difficulty_button,
    input  logic                  speed_button,
    input  logic [NUM_COLORS-1:0] btn,
    output logic [NUM_COLORS-1:0] led,
    output logic [ADDR_WIDTH:0]   lcd_display,
    output logic                  busy,
    output logic                  win,
    output logic                  lose
);

    localparam int LEN_W   = ADDR_WIDTH + 1;
    localparam int MAX_SEQ = 2 ** ADDR_WIDTH;
    localparam int TIMER_W = 32;

    state_t                  state_reg, state_next;
    logic [LEN_W-1:0]        len_reg, len_next, idx_reg, idx_next;
    logic [LEN_W-1:0]        target_reg, target_next, score_reg, score_next;
    logic [TIMER_W-1:0]      timer_reg, timer_next, period_reg, period_next;
    logic                    mode_reg, mode_next;
    logic [NUM_COLORS-1:0]   btn_q;
    logic                    start_q;

    color_t                  mem [MAX_SEQ];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    color_t                  mem_wdata;

    logic [COLOR_CODEFY_W-1:0] rnd;
    logic [NUM_COLORS-1:0]   press, expect_onehot;
    logic                    start_edge, press_any, press_single, timed_out;
    color_t                  press_code;

    genius_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .OUT_W (COLOR_CODEFY_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .rnd   (rnd)
    );

    assign start_edge    = start & ~start_q;
    assign press         = btn & ~btn_q;
    assign press_any     = |press;
    assign press_single  = press_any && ((press & (press - NUM_COLORS'(1))) == '0);
    assign expect_onehot = NUM_COLORS'(1) << mem[idx_reg[ADDR_WIDTH-1:0]];
    assign timed_out     = (timer_reg == TIMER_W'(TIMEOUT_CYC - 1));

    always_comb begin
        press_code = '0;
        for (int i = 0; i < NUM_COLORS; i++) begin
            if (press[i]) press_code = color_t'(i);
        end
    end

    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        idx_next    = idx_reg;
        target_next = target_reg;
        score_next  = score_reg;
        period_next = period_reg;
        mode_next   = mode_reg;
        timer_next  = timer_reg + TIMER_W'(1);
        mem_we      = 1'b0;
        mem_waddr   = len_reg[ADDR_WIDTH-1:0];
        mem_wdata   = color_t'(rnd);

        unique case (state_reg)
            IDLE, WIN, LOSE: begin
                if (start_edge) begin
                    len_next    = '0;
                    idx_next    = '0;
                    score_next  = '0;
                    timer_next  = '0;
                    mode_next   = mode_button;
                    target_next = LEN_W'(target_len(difficulty_button, ADDR_WIDTH));
                    period_next = speed_button ? TIMER_W'(SHOW_CYC / 2) : TIMER_W'(SHOW_CYC);
                    state_next  = mode_button ? WAIT_ADD : ADD;
                end
            end
            ADD: begin
                mem_we     = 1'b1;
                len_next   = len_reg + LEN_W'(1);
                idx_next   = '0;
                timer_next = '0;
                state_next = SHOW_ON;
            end
            SHOW_ON: begin
                if (timer_reg == period_reg - TIMER_W'(1)) begin
                    timer_next = '0;
                    state_next = SHOW_OFF;
                end
            end
            SHOW_OFF: begin
                if (timer_reg == period_reg - TIMER_W'(1)) begin
                    timer_next = '0;
                    if (idx_reg + LEN_W'(1) == len_reg) begin
                        idx_next   = '0;
                        state_next = WAIT_IN;
                    end else begin
                        idx_next   = idx_reg + LEN_W'(1);
                        state_next = SHOW_ON;
                    end
                end
            end
            WAIT_IN: begin
                if (press_any) begin
                    timer_next = '0;
                    if (press != expect_onehot) begin
                        state_next = LOSE;
                    end else if (idx_reg == len_reg - LEN_W'(1)) begin
                        // Player mode appends a colour after each full repeat.
                        idx_next   = '0;
                        state_next = mode_reg ? WAIT_ADD : ROUND_END;
                    end else begin
                        idx_next = idx_reg + LEN_W'(1);
                    end
                end else if (timed_out) begin
                    state_next = LOSE;
                end
            end
            WAIT_ADD: begin
                if (press_any) begin
                    timer_next = '0;
                    if (press_single) begin
                        mem_we     = 1'b1;
                        mem_wdata  = press_code;
                        len_next   = len_reg + LEN_W'(1);
                        state_next = ROUND_END;
                    end
                end else if (timed_out) begin
                    state_next = LOSE;
                end
            end
            ROUND_END: begin
                score_next = len_reg;
                idx_next   = '0;
                timer_next = '0;
                if (len_reg == target_reg) begin
                    state_next = WIN;
                end else begin
                    state_next = mode_reg ? WAIT_IN : ADD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            len_reg    <= '0;
            idx_reg    <= '0;
            target_reg <= '0;
            score_reg  <= '0;
            timer_reg  <= '0;
            period_reg <= '0;
            mode_reg   <= 1'b0;
            btn_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            idx_reg    <= idx_next;
            target_reg <= target_next;
            score_reg  <= score_next;
            timer_reg  <= timer_next;
            period_reg <= period_next;
            mode_reg   <= mode_next;
            btn_q      <= btn;
            start_q    <= start;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        led = '0;
        unique case (state_reg)
            SHOW_ON:           led = expect_onehot;
            WAIT_IN, WAIT_ADD: led = btn;
            WIN:               led = '1;
            default:           led = '0;
        endcase
    end

    assign busy        = !(state_reg inside {IDLE, WIN, LOSE});
    assign win         = (state_reg == WIN);
    assign lose        = (state_reg == LOSE);
    assign lcd_display = score_reg;

endmodule

// File: tb/tb_genius_ctrl_n.sv
// Directed-plus-random bench for genius_ctrl_n with an LFSR/sequence model.
module tb_genius_ctrl_n;

    localparam int NC = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mode_button;
    logic [1:0]    difficulty_button;
    logic          speed_button;
    logic [NC-1:0] btn;
    logic [NC-1:0] led;
    logic [AW:0]   lcd_display;
    logic          busy;
    logic          win;
    logic          lose;

    int total = 0;
    int bad   = 0;
    int seq[$];
    logic [15:0] m_lfsr;

    genius_ctrl_n #(
        .NUM_COLORS     (NC),
        .COLOR_CODEFY_W (2),
        .ADDR_WIDTH     (AW),
        .LFSR_WIDTH     (16),
        .SHOW_CYC       (4),
        .TIMEOUT_CYC    (20)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .mode_button       (mode_button),
        .difficulty_button (difficulty_button),
        .speed_button      (speed_button),
        .btn               (btn),
        .led               (led),
        .lcd_display       (lcd_display),
        .busy              (busy),
        .win               (win),
        .lose              (lose)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, seeded on reset, stepping every cycle.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC-1:0] onehot(input int c);
        return NC'(1 << c);
    endfunction

    // Returns with the DUT in its first game state (ADD or WAIT_ADD).
    task automatic start_game(input logic mode, input logic [1:0] diff, input logic fast);
        start = 1'b0;
        tick();
        mode_button       = mode;
        difficulty_button = diff;
        speed_button      = fast;
        start             = 1'b1;
        tick();
        start = 1'b0;
        seq.delete();
        check("start_busy", busy, 1);
        check("start_lose", lose, 0);
        if (!mode) seq.push_back(int'(m_lfsr[1:0]));
    endtask

    task automatic show(input int period);
        for (int i = 0; i < seq.size(); i++) begin
            repeat (period) begin
                tick();
                check("show_on", led, onehot(seq[i]));
            end
            repeat (period) begin
                tick();
                check("show_off", led, 0);
            end
        end
    endtask

    // Plays one machine-mode round from the ADD cycle to just after ROUND_END.
    task automatic machine_round(input int period);
        show(period);
        tick();
        for (int i = 0; i < seq.size(); i++) begin
            btn = onehot(seq[i]);
            #1;
            check("echo", led, btn);
            tick();
            btn = '0;
            if (i != seq.size() - 1) repeat ($urandom_range(1, 3)) tick();
        end
        tick();
        check("score", lcd_display, seq.size());
    endtask

    initial begin
        int other;
        rst_n = 1'b0; start = 1'b0; mode_button = 1'b0;
        difficulty_button = 2'b00; speed_button = 1'b0; btn = '0;
        tick();
        tick();
        check("rst_led", led, 0);
        check("rst_lcd", lcd_display, 0);
        check("rst_busy", busy, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        rst_n = 1'b1;

        // Machine mode, target 2, slow playback.
        start_game(1'b0, 2'b00, 1'b0);
        machine_round(4);
        check("m_r1_win", win, 0);
        seq.push_back(int'(m_lfsr[1:0]));
        machine_round(4);
        check("m_win", win, 1);
        check("m_win_led", led, 4'b1111);
        check("m_win_busy", busy, 0);

        // Wrong colour in round 1, fast playback.
        start_game(1'b0, 2'b00, 1'b1);
        show(2);
        tick();
        other = (seq[0] + int'($urandom_range(1, 3))) % NC;
        btn = onehot(other);
        tick();
        btn = '0;
        check("wrong_lose", lose, 1);
        check("wrong_lcd", lcd_display, 0);
        check("wrong_led", led, 0);
        check("wrong_busy", busy, 0);

        // Restart after LOSE, then a double press containing the right colour.
        start_game(1'b0, 2'b00, 1'b1);
        machine_round(2);
        seq.push_back(int'(m_lfsr[1:0]));
        show(2);
        tick();
        other = (seq[0] + int'($urandom_range(1, 3))) % NC;
        btn = onehot(seq[0]) | onehot(other);
        tick();
        btn = '0;
        check("double_lose", lose, 1);
        check("double_lcd", lcd_display, 1);

        // Timeout: a press on idle cycle 19 survives, a full 20 idle cycles loses.
        start_game(1'b0, 2'b01, 1'b0);
        machine_round(4);
        seq.push_back(int'(m_lfsr[1:0]));
        show(4);
        tick();
        repeat (19) tick();
        check("to_pre", lose, 0);
        btn = onehot(seq[0]);
        tick();
        btn = '0;
        check("to_press", lose, 0);
        repeat (19) tick();
        check("to_edge", lose, 0);
        tick();
        check("to_lose", lose, 1);
        check("to_lcd", lcd_display, 1);

        // Player mode, fast, target 2: add 2, then repeat 2 (held) and add 1.
        start_game(1'b1, 2'b00, 1'b1);
        btn = onehot(2);
        tick();
        btn = '0;
        tick();
        check("p_lcd1", lcd_display, 1);
        btn = onehot(2);
        #1;
        check("p_echo", led, onehot(2));
        repeat (10) tick();
        check("p_hold_lcd", lcd_display, 1);
        check("p_hold_win", win, 0);
        check("p_hold_busy", busy, 1);
        btn = '0;
        tick();
        btn = onehot(1);
        tick();
        btn = '0;
        tick();
        check("p_lcd2", lcd_display, 2);
        check("p_win", win, 1);
        check("p_win_led", led, 4'b1111);

        // Reset asserted while a colour is on the LEDs.
        start_game(1'b0, 2'b01, 1'b0);
        machine_round(4);
        seq.push_back(int'(m_lfsr[1:0]));
        tick();
        check("mid_led", led, onehot(seq[0]));
        rst_n = 1'b0;
        tick();
        check("mid_rst_led", led, 0);
        check("mid_rst_lcd", lcd_display, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_win", win, 0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/genius_ctrl_n.md
Name: genius_ctrl_n

Overview:
Parametrised next-generation Genius (Simon) game controller for NUM_COLORS colour channels and a sequence memory of 2**ADDR_WIDTH entries. It generates the sequence from an LFSR or from player input, plays it back on the LEDs with a speed-dependent period, checks player entries, and applies a per-press input timeout. It sits between the debounced button/switch inputs and the LED/LCD outputs at the top level.

Parameters:
NUM_COLORS, 4, number of colour channels; legal values 2, 4, 8.
COLOR_CODEFY_W, 2, colour code width; must equal log2(NUM_COLORS).
ADDR_WIDTH, 5, sequence memory address width; MAX_SEQ = 2**ADDR_WIDTH.
LFSR_WIDTH, 16, LFSR width.
SHOW_CYC, 50_000_000, LED on-cycles and off-cycles per step at slow speed.
TIMEOUT_CYC, 500_000_000, maximum idle cycles allowed between player presses.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
start  in  1  level input; rising edge starts a game.
mode_button  in  1  0 = machine mode (LFSR appends); 1 = "mando eu" mode (player appends); sampled at start.
difficulty_button  in  2  selects target length; sampled at start.
speed_button  in  1  0 = slow, 1 = fast; sampled at start.
btn  in  NUM_COLORS  debounced colour buttons, one bit per colour.
led  out  NUM_COLORS  colour LEDs.
lcd_display  out  ADDR_WIDTH+1  score (completed rounds).
busy  out  1  high when the controller is in any state other than IDLE, WIN or LOSE.
win  out  1  high while in WIN.
lose  out  1  high while in LOSE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; led, lcd_display, busy, win, lose = 0; length=0; LFSR = seed 16'hACE1; timers cleared. Reset in the middle of a game aborts it on the same edge.
- Edge detection: btn and start are registered; press = btn & ~btn_q. A held button counts once.
- Press validity: more than one press bit set in the same cycle is a wrong entry.
- LFSR: Fibonacci, taps 16,14,13,11. Free-running every cycle, including IDLE. Its value is never 0.
- Configuration at start: target = (difficulty_button+1) * MAX_SEQ/4. With ADDR_WIDTH=5 this gives 8, 16, 24 or 32. Step period is SHOW_CYC when slow and SHOW_CYC/2 when fast. Mode, target and speed stay latched for the whole game.
- IDLE: on a start edge, length=0, then go to ADD (machine mode) or WAIT_ADD (player mode).
- ADD: mem[length] = lfsr[COLOR_CODEFY_W-1:0]; length++; idx=0; go to SHOW_ON. Takes 1 cycle.
- SHOW_ON: led = onehot(mem[idx]) for one period, then go to SHOW_OFF.
- SHOW_OFF: led = 0 for one period. Then idx++; if idx == length, idx=0 and go to WAIT_IN; otherwise go to SHOW_ON.
- WAIT_IN: led = btn (echo). On a press:
  - correct and idx < length-1: idx++.
  - correct and idx == length-1: go to ROUND_END.
  - wrong entry: go to LOSE.
  - no press for TIMEOUT_CYC cycles: go to LOSE. The timeout counter restarts on every press.
- Player mode:
  - The sequence is not shown after round 1.
  - After a correct full repeat, enter WAIT_ADD.
  - In WAIT_ADD, the next valid single press is written to mem[length] and length is incremented. The timeout also applies here.
  - Round 1 goes straight from WAIT_ADD to ROUND_END once the first colour is stored.
- ROUND_END: lcd_display = length. If length == target, go to WIN. Otherwise go to ADD (machine mode) or WAIT_ADD (player mode), with idx=0.
- WIN: led = all ones, win=1. LOSE: led = 0, lose=1, lcd_display holds the last completed score. From either state, a start edge begins a new game.
- A start edge while busy is ignored. Presses during SHOW_ON, SHOW_OFF and ADD are ignored and are not queued.
- length never exceeds MAX_SEQ, because target <= MAX_SEQ.

Decomposition:
- genius_pkg: state_t enum (IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WAIT_ADD, ROUND_END, WIN, LOSE); color_t typedef; LFSR seed and tap constants; target-length function.
- Sub-module genius_lfsr (parametrised width and seed, with an enable input).
- Sequence memory is an inferred register array inside genius_ctrl_n.

Test Plan:
Bench parameters for all scenarios: ADDR_WIDTH=3, SHOW_CYC=4, TIMEOUT_CYC=20, NUM_COLORS=4.
1. Reset held during SHOW_ON -> next edge gives state=IDLE, led=0, lcd_display=0, busy=0.
2. Machine mode, difficulty=00 (target 2), bench replays the sequence from an LFSR model -> LEDs on for 4 cycles and off for 4 cycles per step; lcd_display goes 1 then 2; win=1 with led=4'b1111.
3. Round 1 with a wrong colour pressed -> lose=1 on the next cycle, lcd_display=0. Then a start edge -> busy=1 and length restarts at 1.
4. Same as scenario 3, but with two buttons pressed in the same cycle where one of them is correct -> lose=1.
5. No press for 20 cycles in WAIT_IN -> lose=1. A press at cycle 19 restarts the counter and no lose occurs.
6. Player mode, fast speed, difficulty=00: presses 2, then 2,1 -> lcd_display=1 then 2, win=1. A button held across 10 cycles counts as exactly one press.
